// File: rtl/button_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// button_arbiter_pkg
//
// Shared definitions for the button arbiter slice:
//   YES / NO      - single-bit truth constants used for handshake signals
//   arb_state_t   - two-state arbiter FSM encoding
//   wrap_inc()    - modulo increment used for the round-robin pointer
// -----------------------------------------------------------------------------
package button_arbiter_pkg;

    localparam logic YES = 1'b1;
    localparam logic NO  = 1'b0;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

    // Increment with explicit wrap so non-power-of-two counts stay in range.
    function automatic int wrap_inc(input int value, input int modulus);
        return (value + 1 >= modulus) ? 0 : value + 1;
    endfunction

endpackage : button_arbiter_pkg

// File: rtl/button_arbiter_if.sv
// -----------------------------------------------------------------------------
// button_arbiter_if
//
// Bundles the request side (one valid/ready pair per button) and the merged
// downstream event stream (valid/ready plus button index).
//   req_valid  [BUTTONS]    per-button event pending
//   req_ready  [BUTTONS]    per-button one-cycle acknowledge
//   out_valid               event offered downstream
//   out_ready               downstream accepts the event
//   out_code   [CODE_WIDTH] index of the granted button
//
// Modports:
//   master - the arbiter (drives acknowledges and the merged stream)
//   slave  - the environment (buttons and downstream consumer)
// -----------------------------------------------------------------------------
interface button_arbiter_if #(
    parameter int BUTTONS    = 4,
    parameter int CODE_WIDTH = $clog2(BUTTONS)
);

    logic [BUTTONS-1:0]    req_valid;
    logic [BUTTONS-1:0]    req_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [CODE_WIDTH-1:0] out_code;

    modport master (
        input  req_valid,
        input  out_ready,
        output req_ready,
        output out_valid,
        output out_code
    );

    modport slave (
        output req_valid,
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  out_code
    );

endinterface : button_arbiter_if

// File: rtl/button_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//
// Combinational rotating priority encoder. Scans the request vector starting
// at 'pointer' and wrapping from N-1 back to 0; the first set bit wins.
//   req     [N]  request vector
//   pointer [W]  highest-priority index for this scan (must be < N)
//   found        at least one request is set
//   index   [W]  winning index (0 when nothing is found)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] pointer,
    output logic         found,
    output logic [W-1:0] index
);

    always_comb begin
        int cand;
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment; otherwise synthesis infers a latch.
        found = 1'b0;
        index = '0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(pointer) + i) % N;
            if (!found && req[cand]) begin
                found = 1'b1;
                index = W'(cand);
            end
        end
    end

endmodule : rr_pick

// File: rtl/button_arbiter.sv
// -----------------------------------------------------------------------------
// button_arbiter
//
// Round-robin arbiter merging several debounced push-button event streams into
// one key-event stream carrying the button index. A request is acknowledged at
// grant time, so the event lives only in out_code until downstream accepts it.
// All outputs are registered; no input reaches an output combinationally.
//
// Ports:
//   clk        sole clock, rising edge
//   reset_low  asynchronous, active-low reset
//   bus        button_arbiter_if.master (requests in, merged stream out)
//
// Parameters:
//   BUTTONS    number of requesters, 2..8
//   CODE_WIDTH index width, derived from BUTTONS; leave at default
// -----------------------------------------------------------------------------
module button_arbiter
    import button_arbiter_pkg::*;
#(
    parameter int BUTTONS    = 4,
    parameter int CODE_WIDTH = $clog2(BUTTONS)
) (
    input  logic                clk,
    input  logic                reset_low,
    button_arbiter_if.master    bus
);

    localparam logic [BUTTONS-1:0] ONE_HOT_LSB = BUTTONS'(1);

    arb_state_t            state_q,     state_d;
    logic [CODE_WIDTH-1:0] pointer_q,   pointer_d;
    logic                  out_valid_q, out_valid_d;
    logic [CODE_WIDTH-1:0] out_code_q,  out_code_d;
    logic [BUTTONS-1:0]    req_ready_q, req_ready_d;

    logic                  pick_found;
    logic [CODE_WIDTH-1:0] pick_index;

    rr_pick #(
        .N (BUTTONS),
        .W (CODE_WIDTH)
    ) u_rr_pick (
        .req     (bus.req_valid),
        .pointer (pointer_q),
        .found   (pick_found),
        .index   (pick_index)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        pointer_d   = pointer_q;
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        req_ready_d = '0;           // acknowledge is a single-cycle pulse

        case (state_q)
            IDLE: begin
                out_valid_d = NO;
                if (pick_found) begin
                    out_code_d  = pick_index;
                    out_valid_d = YES;
                    req_ready_d = ONE_HOT_LSB << pick_index;
                    state_d     = OFFER;
                end
            end
            OFFER: begin
                if (bus.out_ready == YES) begin
                    out_valid_d = NO;
                    // Next scan starts just after the button just served.
                    pointer_d   = CODE_WIDTH'(wrap_inc(int'(out_code_q), BUTTONS));
                    state_d     = IDLE;
                end
            end
        endcase
    end

    // State and output registers. Reset discards any in-flight event.
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            state_q     <= IDLE;
            pointer_q   <= '0;
            out_valid_q <= NO;
            out_code_q  <= '0;
            req_ready_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            pointer_q   <= pointer_d;
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_code  = out_code_q;
    assign bus.req_ready = req_ready_q;

endmodule : button_arbiter

// File: tb/tb_button_arbiter.sv
// -----------------------------------------------------------------------------
// tb_button_arbiter
//
// Directed bench for button_arbiter with BUTTONS=4. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_button_arbiter;

    localparam int BUTTONS = 4;
    localparam int CW      = 2;

    logic clk;
    logic reset_low;

    int vectors;
    int miscompares;

    button_arbiter_if #(.BUTTONS(BUTTONS)) bus ();

    button_arbiter #(.BUTTONS(BUTTONS)) dut (
        .clk       (clk),
        .reset_low (reset_low),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_low = 1'b0;
        tick();
        tick();
        reset_low = 1'b1;
    endtask

    // Compare all three outputs against expected values.
    task automatic expect_out(input string name, input logic ev,
                              input logic [CW-1:0] ec, input logic [BUTTONS-1:0] er);
        vectors++;
        if (bus.out_valid !== ev) begin
            miscompares++;
            $display("FAIL %s out_valid: got %b expected %b", name, bus.out_valid, ev);
        end
        vectors++;
        if (bus.out_code !== ec) begin
            miscompares++;
            $display("FAIL %s out_code: got %0d expected %0d", name, bus.out_code, ec);
        end
        vectors++;
        if (bus.req_ready !== er) begin
            miscompares++;
            $display("FAIL %s req_ready: got %b expected %b", name, bus.req_ready, er);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;
        reset_low     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("reset_hold", 1'b0, 2'd0, 4'b0000);
        end
        reset_low = 1'b1;
        tick();
        expect_out("reset_first_grant", 1'b1, 2'd0, 4'b0001);
        bus.req_valid = 4'b0000;
        tick();
        expect_out("reset_first_accept", 1'b0, 2'd0, 4'b0000);
    endtask

    task automatic test_single_press();
        bus.req_valid = 4'b0000;
        bus.out_ready = 1'b1;
        apply_reset();
        bus.req_valid = 4'b0100;
        tick();
        expect_out("single_grant", 1'b1, 2'd2, 4'b0100);
        bus.req_valid = 4'b0000;
        tick();
        expect_out("single_accept", 1'b0, 2'd2, 4'b0000);
        tick();
        expect_out("single_idle", 1'b0, 2'd2, 4'b0000);
    endtask

    task automatic test_round_robin();
        logic [CW-1:0] code;
        bus.req_valid = 4'b0000;
        bus.out_ready = 1'b1;
        apply_reset();
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            code = CW'(k % BUTTONS);
            tick();
            expect_out("rr_grant", 1'b1, code, 4'b0001 << code);
            tick();
            expect_out("rr_accept", 1'b0, code, 4'b0000);
        end
        bus.req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        bus.req_valid = 4'b0000;
        bus.out_ready = 1'b0;
        apply_reset();
        bus.req_valid = 4'b0010;
        tick();
        expect_out("bp_grant", 1'b1, 2'd1, 4'b0010);
        bus.req_valid = 4'b1101;            // others pending while stalled
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_out("bp_stall", 1'b1, 2'd1, 4'b0000);
        end
        bus.req_valid = 4'b0000;
        bus.out_ready = 1'b1;
        tick();
        expect_out("bp_release", 1'b0, 2'd1, 4'b0000);
        tick();
        expect_out("bp_single_event", 1'b0, 2'd1, 4'b0000);
        bus.req_valid = 4'b1111;            // pointer must now be 2
        tick();
        expect_out("bp_next_pointer", 1'b1, 2'd2, 4'b0100);
        bus.req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_repress();
        logic [BUTTONS-1:0] pending;
        bus.req_valid = 4'b0000;
        bus.out_ready = 1'b0;
        apply_reset();
        bus.req_valid = 4'b1000;
        tick();
        expect_out("repress_grant3", 1'b1, 2'd3, 4'b1000);
        pending       = 4'b1111;            // button 3 re-pressed, 0..2 waiting
        bus.req_valid = pending;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("repress_stall", 1'b1, 2'd3, 4'b0000);
        end
        bus.out_ready = 1'b1;
        tick();
        expect_out("repress_accept", 1'b0, 2'd3, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_out("repress_order", 1'b1, CW'(k), 4'b0001 << k);
            pending[k]    = 1'b0;
            bus.req_valid = pending;
            tick();
            expect_out("repress_order_accept", 1'b0, CW'(k), 4'b0000);
        end
    endtask

    task automatic test_reset_mid_offer();
        bus.req_valid = 4'b0000;
        bus.out_ready = 1'b0;
        apply_reset();
        bus.req_valid = 4'b0100;
        tick();
        expect_out("mid_offer_grant", 1'b1, 2'd2, 4'b0100);
        #2;
        reset_low = 1'b0;
        #1;                                 // still before the next edge
        expect_out("mid_offer_async_drop", 1'b0, 2'd0, 4'b0000);
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;
        reset_low     = 1'b1;
        tick();
        expect_out("mid_offer_pointer0", 1'b1, 2'd0, 4'b0001);
        bus.req_valid = 4'b0000;
        tick();
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset_low     = 1'b0;
        bus.req_valid = '0;
        bus.out_ready = 1'b0;

        test_reset();
        test_single_press();
        test_round_robin();
        test_backpressure();
        test_repress();
        test_reset_mid_offer();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_button_arbiter

// File: doc/button_arbiter.md
# button_arbiter

Round-robin arbiter that merges the valid/ready event streams of several debounced push-buttons into one key-event stream carrying a button index. It sits between the per-button handshake blocks and the single downstream consumer, such as the keyboard/command input of the terminal core. It guarantees each press is consumed exactly once and that no button is starved.

## Interface

- `BUTTONS`, default 4: number of requesters, legal range 2..8.
- `CODE_WIDTH`, default `$clog2(BUTTONS)`: width of the index output. Must not be overridden.

- `clk`  input  1  sole clock; all logic on its rising edge.
- `reset_low`  input  1  asynchronous, active-low reset.
- `req_valid`  input  BUTTONS  per-button event pending. Stays high until acknowledged.
- `req_ready`  output  BUTTONS  per-button acknowledge. One-hot, single-cycle pulse.
- `out_valid`  output  1  event offered downstream.
- `out_ready`  input  1  downstream accepts the event.
- `out_code`  output  CODE_WIDTH  index of the granted button.

## Operation

- Shared constants `YES`/`NO` and the state enum come from the common package.
- State machine, two states:
  - `IDLE`: `out_valid`=NO. Scan `req_valid` in rotating order, starting at `pointer` and wrapping from `BUTTONS-1` to 0. The first set bit wins, index `g`. At the next edge:
    - `out_code`<=g
    - `out_valid`<=YES
    - `req_ready[g]`<=YES
    - move to `OFFER`.
  - If no bit is set in `IDLE`, stay in `IDLE`. All outputs hold.
  - `OFFER`: `out_valid`=YES and `out_code` is stable. `req_ready` returns to all-zero after its single cycle. On an edge with `out_ready`=YES:
    - `out_valid`<=NO
    - `pointer`<=(g+1) mod BUTTONS
    - go to `IDLE`.
- `pointer` is CODE_WIDTH bits wide. Wrap is explicit modulo BUTTONS, which also covers non-power-of-two counts.
- Acknowledge happens at grant, not at downstream accept. This frees the requester immediately; the event is held solely in `out_code`.
- A new press on button g during `OFFER` re-raises `req_valid[g]`. It is served later under round-robin order.
- `req_valid` bits that drop before being sampled in `IDLE` are never granted.
- `out_ready` in `IDLE` is ignored.
- Reset (any time, including mid-`OFFER`):
  - state=`IDLE`, `pointer`=0, `out_valid`=NO, `out_code`=0, `req_ready`=0.
  - An in-flight event is discarded.

## Timing

- Reset values: `out_valid`=0, `out_code`=0, `req_ready`=0, state `IDLE`, `pointer`=0.
- `req_valid[i]` sampled high in `IDLE` at edge n:
  - `out_valid` and `req_ready[i]` are high from edge n+1.
  - `req_ready[i]` is low again from edge n+2.
- `out_ready` high at edge m in `OFFER`: `out_valid` is low from edge m+1.
- Earliest next grant: `out_valid` high again from edge m+2. Peak throughput is one event per 2 cycles.
- All outputs are registered. There is no combinational path from any input to any output.
- Fairness bound: a continuously pending request is granted within BUTTONS grants.

## Structure

- Package holds `YES`/`NO` and `typedef enum logic {IDLE, OFFER} arb_state_t`.
- One sub-module: `rr_pick`, a combinational rotating priority encoder.
  - Inputs: request vector, `pointer`.
  - Outputs: `found`, index.
  - Reusable by future arbiters.
- Top level holds the FSM, `pointer`, and the output registers.

## Test plan

- Reset: hold `reset_low`=0 with `req_valid`=4'b1111 -> `out_valid`=0 and `req_ready`=0 throughout. After release, the first grant is `out_code`=0.
- Single press: `req_valid`=4'b0100 in `IDLE`, `out_ready`=1 ->
  - `out_code`=2 and `req_ready`=4'b0100 for exactly 1 cycle, one edge after sampling.
  - `out_valid` falls one edge later.
- Round-robin: `req_valid`=4'b1111 held, `out_ready`=1 -> codes 0,1,2,3,0, one every 2 cycles.
- Backpressure: `out_ready`=0 for 10 cycles after a grant of code 1 ->
  - `out_valid` and `out_code`=1 stay stable.
  - No further `req_ready` pulses.
  - Releasing `out_ready` delivers one event only.
- Re-press during `OFFER`: button 3 granted, its `req_valid` re-raised while stalled -> after accept, code 3 is granted again only after pending buttons 0..2.
- Reset mid-`OFFER`: assert `reset_low`=0 while `out_valid`=1 -> `out_valid` drops asynchronously. `pointer` restarts at 0.
